// File: rtl/frame_buffer.sv
// -----------------------------------------------------------------------------
// frame_buffer
//
// Purpose:
//   RAM-based FIFO for completed trace frames. Frames arrive as single-cycle
//   strobes, are stored in an inferred block RAM with a registered read, and
//   the oldest stored frame is presented show-ahead on Frame/FrameValid.
//   Reports a full-scale occupancy count and a high-water flag. On overflow it
//   either drops the newest frame or overwrites the oldest one, selected by
//   Overwrite. Flush clears the whole buffer synchronously.
//
// Optional feature:
//   FRAME_BUFFER_LOSTCNT_EN - when defined, adds the LostCnt output. LostCnt is
//   a saturating 16-bit count of frames lost to overflow. It is cleared only by
//   rst.
//
// Parameters:
//   FRAMEWIDTH  - bits per frame
//   BUFFLENLOG2 - log2 of the storage depth (DEPTH = 2**BUFFLENLOG2), >= 2
//   HIWATER     - occupancy at or above which HiWater is asserted
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   PkAvail    in   single-cycle strobe, Packet valid
//   Packet     in   incoming frame
//   Overwrite  in   overflow policy: 0 drop newest, 1 overwrite oldest
//   Flush      in   synchronous clear of all stored frames (highest priority)
//   Frame      out  head frame, valid while FrameValid = 1
//   FrameValid out  head frame present
//   FrameNext  in   pop the head (ignored while FrameValid = 0)
//   FramesCnt  out  frames held, 0..DEPTH
//   HiWater    out  FramesCnt >= HIWATER
//   DataOverf  out  one-cycle pulse for every frame lost to overflow
//   LostCnt    out  (FRAME_BUFFER_LOSTCNT_EN only) saturating loss count
// -----------------------------------------------------------------------------
module frame_buffer #(
  parameter int FRAMEWIDTH  = 128,
  parameter int BUFFLENLOG2 = 9,
  parameter int HIWATER     = (3 * (1 << BUFFLENLOG2)) / 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   PkAvail,
  input  logic [FRAMEWIDTH-1:0]  Packet,
  input  logic                   Overwrite,
  input  logic                   Flush,
  output logic [FRAMEWIDTH-1:0]  Frame,
  output logic                   FrameValid,
  input  logic                   FrameNext,
  output logic [BUFFLENLOG2:0]   FramesCnt,
  output logic                   HiWater,
  output logic                   DataOverf
`ifdef FRAME_BUFFER_LOSTCNT_EN
  ,
  output logic [15:0]            LostCnt
`endif
);

  localparam int            DEPTH     = 1 << BUFFLENLOG2;
  localparam int            CW        = BUFFLENLOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] HIWATER_C = CW'(HIWATER);

  // Storage and read pipeline
  logic [FRAMEWIDTH-1:0]  mem [DEPTH];
  logic [BUFFLENLOG2-1:0] wr_ptr_reg;
  logic [BUFFLENLOG2-1:0] rd_ptr_reg;
  logic [CW-1:0]          count_reg;
  logic [CW-1:0]          count_next;
  logic [FRAMEWIDTH-1:0]  rdata_reg;        // registered RAM read data
  logic                   rdata_valid_reg;  // rdata_reg holds a stored frame

  // Per-cycle decisions
  logic          full;
  logic          pop_user;
  logic          ovf_event;
  logic          drop_oldest;
  logic          pop_int;
  logic          wr_en;
  logic          out_load;
  logic          fetch;
  logic [CW-1:0] fetched;
  logic [CW-1:0] unread;

  assign FramesCnt = count_reg;

  // The count covers three places a frame can sit: the output register, the
  // RAM read register and the RAM itself. Frames already moved into the read
  // pipeline no longer occupy RAM slots, so the RAM never holds more than
  // DEPTH entries. The read-address slot never equals the write-address slot
  // while unread entries exist, because with DEPTH >= 4 the pipeline has
  // always fetched at least one frame by the time the buffer is full.
  always_comb begin
    full        = (count_reg == DEPTH_C);
    pop_user    = FrameNext & FrameValid;
    // A loss only happens when a write meets a full buffer that nobody pops.
    ovf_event   = PkAvail & full & ~pop_user & ~Flush;
    // Overwriting the oldest frame is an internal pop of the head. A full
    // buffer always has FrameValid set, so the head is the oldest frame.
    drop_oldest = ovf_event & Overwrite;
    pop_int     = pop_user | drop_oldest;
    wr_en       = PkAvail & ~Flush & (~full | pop_int);

    // Output stage takes the prefetched frame whenever it is empty or its
    // current frame leaves this cycle. That gives back-to-back pops.
    out_load    = rdata_valid_reg & (~FrameValid | pop_int);
    fetched     = CW'(FrameValid) + CW'(rdata_valid_reg);
    unread      = count_reg - fetched;
    // Refill the read register when it is empty or about to move forward.
    fetch       = ~Flush & (unread != '0) & (~rdata_valid_reg | out_load);

    count_next  = count_reg;
    if (Flush) begin
      count_next = '0;
    end else if (wr_en && !pop_int) begin
      count_next = count_reg + CW'(1);
    end else if (!wr_en && pop_int) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Block RAM: no reset, so it maps onto memory primitives. The read is
  // registered.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= Packet;
    end
    if (fetch) begin
      rdata_reg <= mem[rd_ptr_reg];
    end
  end

  // Pointers, occupancy, read pipeline and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      rdata_valid_reg <= 1'b0;
      Frame           <= '0;
      FrameValid      <= 1'b0;
      HiWater         <= 1'b0;
      DataOverf       <= 1'b0;
    end else if (Flush) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      rdata_valid_reg <= 1'b0;
      FrameValid      <= 1'b0;
      HiWater         <= 1'b0;
      DataOverf       <= 1'b0;
    end else begin
      // Pointers are BUFFLENLOG2 bits wide and wrap naturally modulo DEPTH.
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (fetch) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;

      if (out_load) begin
        Frame      <= rdata_reg;
        FrameValid <= 1'b1;
      end else if (pop_int) begin
        FrameValid <= 1'b0;
      end

      if (fetch) begin
        rdata_valid_reg <= 1'b1;
      end else if (out_load) begin
        rdata_valid_reg <= 1'b0;
      end

      // Derived from the next count so the flag changes on the same edge
      // as FramesCnt.
      HiWater   <= (count_next >= HIWATER_C);
      DataOverf <= ovf_event;
    end
  end

`ifdef FRAME_BUFFER_LOSTCNT_EN
  // Counts the loss on the same edge that raises DataOverf. It saturates at
  // all-ones, and Flush does not clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      LostCnt <= '0;
    end else if (ovf_event && (LostCnt != 16'hFFFF)) begin
      LostCnt <= LostCnt + 16'd1;
    end
  end
`endif

endmodule
